// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Which stage owns a grant.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    function automatic arb_state_t owner_state(input owner_t owner);
        return (owner == OWN_DM) ? DATA : FETCH;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding memory access; flags the abort edge.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // The abort happens on the edge that would bring the count to MAX_WAIT.
    assign o_timeout_c = i_count && (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (i_clear) begin
            r_wait_cnt <= '0;
        end else if (i_count) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store,
// with a fetch starvation guard and a wait-state timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);

    arb_state_t      r_state;
    logic [SC_W-1:0] r_starve_cnt;

    logic   w_dm_req;
    logic   w_fetch_forced;
    logic   w_grant;
    owner_t w_owner;
    logic   w_busy;
    logic   w_done;
    logic   w_wait;
    logic   w_timeout;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = (dm_read | dm_write) & ~dm_valid;

    // Grant decode: data wins unless fetch has been starved STARVE_LIM times.
    always_comb begin
        w_dm_req       = dm_read | dm_write;
        w_fetch_forced = if_req && (r_starve_cnt == SC_W'(STARVE_LIM));
        w_grant        = (r_state == IDLE) && (w_dm_req || if_req);
        w_owner        = (w_dm_req && !w_fetch_forced) ? OWN_DM : OWN_IF;
        w_busy         = (r_state != IDLE);
        w_done         = w_busy && mem_ready;
        w_wait         = w_busy && !mem_ready;
    end

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_grant),
        .i_count     (w_wait),
        .o_timeout_c (w_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_valid     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        mem_req <= 1'b1;
                        r_state <= owner_state(w_owner);
                        if (w_owner == OWN_DM) begin
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_write;
                            mem_wdata <= dm_wdata;
                            if (if_req && (r_starve_cnt < SC_W'(STARVE_LIM))) begin
                                r_starve_cnt <= r_starve_cnt + SC_W'(1);
                            end
                        end else begin
                            mem_addr     <= if_addr;
                            mem_we       <= 1'b0;
                            mem_wdata    <= '0;
                            r_starve_cnt <= '0;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (w_done || w_timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= IDLE;
                        bus_err <= w_timeout && !w_done;
                        if (r_state == FETCH) begin
                            if_valid <= 1'b1;
                            if_rdata <= w_done ? mem_rdata : '0;
                        end else begin
                            dm_valid <= 1'b1;
                            // A completed store leaves the last load data intact.
                            if (!w_done) begin
                                dm_rdata <= '0;
                            end else if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
